// File: rtl/fp_subtractor_seq.sv
// Sequential IEEE-754 single-precision subtractor (out = in1 - in2), RNE.
// Bit-serial alignment and normalisation; denormal inputs flush to zero.
module fp_subtractor_seq #(
  parameter int MAX_ALIGN = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
);

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADDSUB,
    NORM,
    ROUND,
    DONE
  } state_t;

  localparam logic [31:0] QNAN  = 32'h7FC0_0000;
  localparam logic [7:0]  MAX_D = 8'(MAX_ALIGN);

  state_t      state;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        sign_a;
  logic        sign_b;
  logic        both_neg;
  logic [26:0] man_a;
  logic [26:0] man_b;
  logic [27:0] man;
  logic [9:0]  exp;
  logic [7:0]  cnt;

  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [22:0] fa;
  logic [22:0] fb;
  logic        za;
  logic        zb;
  logic        nan_a;
  logic        nan_b;
  logic        inf_a;
  logic        inf_b;
  logic        sa;
  logic        sb;
  logic [26:0] ma;
  logic [26:0] mb;
  logic        swap;
  logic [7:0]  big_e;
  logic [7:0]  small_e;
  logic [7:0]  d;

  always_comb begin
    ea    = op1[30:23];
    eb    = op2[30:23];
    fa    = op1[22:0];
    fb    = op2[22:0];
    za    = (ea == 8'h00);
    zb    = (eb == 8'h00);
    nan_a = (ea == 8'hFF) && (fa != 23'h0);
    nan_b = (eb == 8'hFF) && (fb != 23'h0);
    inf_a = (ea == 8'hFF) && (fa == 23'h0);
    inf_b = (eb == 8'hFF) && (fb == 23'h0);
    sa    = op1[31];
    sb    = ~op2[31];
    ma    = za ? 27'h0 : {1'b1, fa, 3'b000};
    mb    = zb ? 27'h0 : {1'b1, fb, 3'b000};
    // flushed operands compare as zero magnitude
    swap  = {eb, (zb ? 23'h0 : fb)} > {ea, (za ? 23'h0 : fa)};
    big_e   = swap ? eb : ea;
    small_e = swap ? ea : eb;
    d       = big_e - small_e;
  end

  logic [27:0] sum;

  always_comb begin
    if (sign_a == sign_b) begin
      sum = {1'b0, man_a} + {1'b0, man_b};
    end else begin
      sum = {1'b0, man_a} - {1'b0, man_b};
    end
  end

  logic        inc;
  logic [24:0] rnd;
  logic [22:0] frac;
  logic [9:0]  rexp;

  always_comb begin
    inc  = man[2] & (man[1] | man[0] | man[3]);
    rnd  = {1'b0, man[26:3]} + {24'h0, inc};
    frac = rnd[24] ? rnd[23:1] : rnd[22:0];
    rexp = exp + {9'h0, rnd[24]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= 32'h0;
      op1       <= 32'h0;
      op2       <= 32'h0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      both_neg  <= 1'b0;
      man_a     <= 27'h0;
      man_b     <= 27'h0;
      man       <= 28'h0;
      exp       <= 10'h0;
      cnt       <= 8'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op1      <= in1;
            op2      <= in2;
            in_ready <= 1'b0;
            state    <= UNPACK;
          end
        end

        UNPACK: begin
          if (nan_a || nan_b) begin
            out       <= QNAN;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (inf_a && inf_b) begin
            out       <= (sa != sb) ? QNAN : {sa, 8'hFF, 23'h0};
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (inf_a || inf_b) begin
            out       <= {(inf_a ? sa : sb), 8'hFF, 23'h0};
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sign_a   <= swap ? sb : sa;
            sign_b   <= swap ? sa : sb;
            man_a    <= swap ? mb : ma;
            man_b    <= swap ? ma : mb;
            both_neg <= sa & sb;
            exp      <= {2'b00, big_e};
            cnt      <= d;
            state    <= (d == 8'h00) ? ADDSUB : ALIGN;
          end
        end

        ALIGN: begin
          if (cnt > MAX_D) begin
            man_b <= (man_b != 27'h0) ? 27'h1 : 27'h0;
            state <= ADDSUB;
          end else begin
            man_b <= {1'b0, man_b[26:2], man_b[1] | man_b[0]};
            cnt   <= cnt - 8'h1;
            if (cnt == 8'h1) begin
              state <= ADDSUB;
            end
          end
        end

        ADDSUB: begin
          man   <= sum;
          state <= (sum[27] || !sum[26]) ? NORM : ROUND;
        end

        NORM: begin
          if (man[27]) begin
            man   <= {1'b0, man[27:2], man[1] | man[0]};
            exp   <= exp + 10'h1;
            state <= ROUND;
          end else if (man == 28'h0) begin
            out       <= {both_neg, 31'h0};
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (exp <= 10'h1) begin
            // the next left shift would reach exponent zero
            out       <= {sign_a, 31'h0};
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            man <= {man[26:0], 1'b0};
            exp <= exp - 10'h1;
            if (man[25]) begin
              state <= ROUND;
            end
          end
        end

        ROUND: begin
          if (rexp >= 10'd255) begin
            out <= {sign_a, 8'hFF, 23'h0};
          end else begin
            out <= {sign_a, rexp[7:0], frac};
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Bench for fp_subtractor_seq: directed cases plus random operands
// scored against an exact-integer subtract-and-round model.
module tb_fp_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in1 = 32'h0;
  logic [31:0] in2 = 32'h0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out;

  int checks = 0;
  int failures = 0;

  fp_subtractor_seq #(.MAX_ALIGN(26)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in1(in1),
    .in2(in2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Exact signed-integer difference, then a single RNE rounding step.
  function automatic logic [31:0] ref_sub(input logic [31:0] a,
                                          input logic [31:0] b);
    logic        sa, sb, sg;
    int          ea, eb, base, p, sh, e;
    logic [63:0] ma, mb, mag, q, rem, half;
    longint      va, vb, s;
    sa = a[31];
    sb = ~b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0))
      return 32'h7FC00000;
    if (ea == 255 && eb == 255)
      return (sa != sb) ? 32'h7FC00000 : {sa, 8'hFF, 23'h0};
    if (ea == 255) return {sa, 8'hFF, 23'h0};
    if (eb == 255) return {sb, 8'hFF, 23'h0};
    ma = (ea == 0) ? 64'h0 : {40'h0, 1'b1, a[22:0]};
    mb = (eb == 0) ? 64'h0 : {40'h0, 1'b1, b[22:0]};
    if (ea == 0) base = eb;
    else if (eb == 0) base = ea;
    else base = (ea < eb) ? ea : eb;
    if (ea != 0) ma = ma << (ea - base);
    if (eb != 0) mb = mb << (eb - base);
    va = longint'(ma);
    vb = longint'(mb);
    if (sa) va = -va;
    if (sb) vb = -vb;
    s = va + vb;
    if (s == 0) return {sa & sb, 31'h0};
    sg  = (s < 0);
    mag = sg ? 64'(-s) : 64'(s);
    p = 63;
    while (!mag[p]) p--;
    if (p >= 23) begin
      sh  = p - 23;
      q   = mag >> sh;
      e   = base + sh;
      if (sh > 0) begin
        rem  = mag & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      end
      if (q[24]) begin
        q = q >> 1;
        e = e + 1;
      end
    end else begin
      q = mag << (23 - p);
      e = base - (23 - p);
      if (e < 1) return {sg, 31'h0};
    end
    if (e >= 255) return {sg, 8'hFF, 23'h0};
    return {sg, 8'(e), q[22:0]};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("out_timeout", 32'h0, 32'h1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] want);
    logic ok;
    issue(a, b);
    wait_out(ok);
    if (ok) check(tag, out, want);
    consume();
  endtask

  function automatic logic [31:0] rand_op(input int e_hint);
    logic [31:0] v;
    int e;
    int r = int'($urandom_range(0, 99));
    e = e_hint;
    if (r < 6) e = 0;
    else if (r < 9) e = 255;
    v = {1'($urandom), 8'(e), 23'($urandom)};
    if (e == 255 && $urandom_range(0, 1) == 0) v[22:0] = 23'h0;
    return v;
  endfunction

  initial begin
    logic        ok;
    logic [31:0] a, b, want;
    int          ea, eb;

    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out", out, 32'h0);
    rst_n = 1'b1;

    run("3_minus_1", 32'h40400000, 32'h3F800000, 32'h40000000);
    run("1_minus_0p75", 32'h3F800000, 32'h3F400000, 32'h3E800000);
    run("1_minus_neg1", 32'h3F800000, 32'hBF800000, 32'h40000000);
    run("1_minus_1", 32'h3F800000, 32'h3F800000, 32'h00000000);
    run("1_minus_2m30", 32'h3F800000, 32'h30800000, 32'h3F800000);
    run("max_minus_negmax", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000);
    run("inf_minus_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000);
    run("nan_in2", 32'h3F800000, 32'h7FC12345, 32'h7FC00000);
    run("negz_minus_posz", 32'h80000000, 32'h00000000, 32'h80000000);
    run("posz_minus_posz", 32'h00000000, 32'h00000000, 32'h00000000);
    run("one_minus_inf", 32'h3F800000, 32'h7F800000, 32'hFF800000);
    run("denorm_flush", 32'h00400000, 32'h3F800000, 32'hBF800000);

    // result held while the consumer stalls
    issue(32'h40400000, 32'h3F800000);
    wait_out(ok);
    for (int i = 0; i < 5; i++) begin
      check("hold_out", out, 32'h40000000);
      check("hold_flags", {30'h0, out_valid, in_ready}, 32'h2);
      @(negedge clk);
    end
    consume();

    // reset while the alignment shifter is busy
    issue(32'h3F800000, 32'h35800000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_flags", {30'h0, out_valid, in_ready}, 32'h1);
    run("after_abort", 32'h3F800000, 32'h35800000, 32'h3F7FFFF0);

    for (int n = 0; n < 160; n++) begin
      case ($urandom_range(0, 3))
        0: ea = int'($urandom_range(1, 6));
        1: ea = int'($urandom_range(248, 254));
        default: ea = int'($urandom_range(1, 254));
      endcase
      eb = ea + int'($urandom_range(0, 60)) - 30;
      if (eb < 1) eb = 1;
      if (eb > 254) eb = 254;
      a = rand_op(ea);
      b = rand_op(eb);
      if ($urandom_range(0, 9) == 0) b = {1'($urandom), a[30:0]};
      want = ref_sub(a, b);
      run("random", a, b, want);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_subtractor_seq.md
Name: fp_subtractor_seq

Overview:
- Sequential IEEE-754 single-precision subtractor computing out = in1 - in2, with round-to-nearest-even.
- Multi-cycle FSM datapath: one-bit-per-cycle alignment and normalisation shifters, guard/round/sticky (GRS) rounding.
- Valid/ready handshakes on both sides; sits beside the combinational adder in the FP ALU as the subtract-direction unit.
- Denormal inputs are flushed to zero.

Parameters:
- MAX_ALIGN, 26, alignment distance above which the smaller operand collapses to sticky-only in a single cycle.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  unit can accept operands (high only in IDLE)
- in1  input  32  minuend, IEEE-754 single
- in2  input  32  subtrahend, IEEE-754 single
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  32  result, IEEE-754 single

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, in_ready=1, out_valid=0, out=32'h0. Reset mid-operation abandons the operation with no output; takes precedence over every other event.
- States: IDLE, UNPACK, ALIGN, ADDSUB, NORM, ROUND, DONE.
- IDLE: on in_valid&in_ready, latch in1/in2 and go to UNPACK. in_ready=0 in all other states.
- UNPACK (1 cycle):
  - Effective sign of B = ~in2[31]; exp==0 operands are treated as signed zero.
  - Specials resolve directly to DONE:
    - Either operand NaN -> 32'h7FC00000.
    - Inf-Inf with equal effective signs differing -> 32'h7FC00000.
    - Single Inf -> that Inf with its effective sign.
  - Otherwise build 27-bit mantissas {1,frac,3'b000} and swap so A has the larger magnitude (exp, then fraction). d = expA - expB.
- ALIGN:
  - d==0: 0 cycles.
  - d>MAX_ALIGN: 1 cycle; B becomes 27'b1 if nonzero, else 0.
  - Otherwise shift B right one bit per cycle, OR-ing shifted-out bits into bit0 (sticky), d cycles.
- ADDSUB (1 cycle): 28-bit add if signs equal, else A-B. Result sign = sign of A.
- NORM:
  - Carry out: 1 cycle, shift right 1 with sticky retained, exp+1.
  - Result zero: out=+0 (32'h00000000), except both operands -0 effective, which gives 32'h80000000. Go to DONE.
  - Otherwise shift left one per cycle, exp-1, until bit26 set. Hitting exp==0 flushes to signed zero.
- ROUND (1 cycle): G=bit2, R=bit1, S=bit0. Increment when G&(R|S|bit3). Mantissa overflow -> shift right, exp+1. exp>=255 -> signed Inf.
- DONE: out_valid=1, out stable until out_valid&out_ready, then IDLE (in_ready=1 next cycle).
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Latency from accept to out_valid: min 4 cycles (UNPACK->ADDSUB->ROUND->DONE), max 4+26+26 cycles.

Test Plan:
- 3.0 - 1.0 (32'h40400000, 32'h3F800000) -> 32'h40000000, d=1 alignment.
- 1.0 - 0.75 (32'h3F800000, 32'h3F400000) -> 32'h3E800000, two NORM left shifts.
- 1.0 - (-1.0) (32'h3F800000, 32'hBF800000) -> 32'h40000000 via carry path. Then 1.0 - 1.0 -> 32'h00000000.
- 1.0 - 2^-30 (32'h3F800000, 32'h30800000) -> sticky-only B, round up through mantissa overflow -> 32'h3F800000.
- Specials:
  - 32'h7F7FFFFF - 32'hFF7FFFFF -> 32'h7F800000.
  - 32'h7F800000 - 32'h7F800000 -> 32'h7FC00000.
  - NaN in2 -> 32'h7FC00000.
- Handshake: hold out_ready=0 for 5 cycles -> out/out_valid stable, in_ready=0. Assert rst_n=0 during ALIGN -> out_valid=0, in_ready=1 next cycle, following op correct.
